// File: rtl/ram_stream_reader_pkg.sv
// Shared types for the wide-port stream reader: FSM state encoding and FIFO entry layout.
package ram_stream_pkg;

  localparam int WORD_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Valid/ready output stream of the RAM stream reader; master is the reader, slave the consumer.
interface ram_stream_if #(
  parameter int dataWidth = 256
) ();

  logic                 m_valid_o;
  logic [dataWidth-1:0] m_data_o;
  logic                 m_last_o;
  logic                 m_ready_i;

  modport master (output m_valid_o, m_data_o, m_last_o, input m_ready_i);
  modport slave  (input m_valid_o, m_data_o, m_last_o, output m_ready_i);

endinterface

// File: rtl/ram_stream_reader_fifo.sv
// Synchronous skid FIFO with flush, occupancy count and a registered head entry.
module ram_stream_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [width-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(depth):0]   count_o,
  output logic                     empty_o,
  output logic [width-1:0]         head_o
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = PTR_W + 1;

  logic [width-1:0] mem [depth];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [width-1:0] head_q, head_d;
  logic             do_push, do_pop, full;

  assign full    = (count_q == CNT_W'(depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = head_q;

  always_comb begin
    do_push  = push_i & ~flush_i;
    do_pop   = pop_i & ~empty_o & ~flush_i;
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    head_d   = head_q;
    // The head register must see a word pushed into an empty (or emptying) FIFO directly.
    if (do_push && (count_q == CNT_W'(do_pop))) begin
      head_d = push_data_i;
    end else if (do_pop && (count_q > CNT_W'(1))) begin
      head_d = mem[rd_ptr_d];
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data_i;
    end
  end

  // Upstream credit accounting must never push into a full FIFO without a matching pop.
  assert property (@(posedge clk) disable iff (rst) !(push_i && !flush_i && full && !pop_i));

endmodule

// File: rtl/ram_stream_reader.sv
// Strided wide-port RAM reader streaming words out over valid/ready with a last flag.
// Optional RAM_STREAM_READER_ABORT_EN adds abort_i to cancel a running command.
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int addrWidth = 32,
  parameter int dataWidth = WORD_W,
  parameter int lenWidth  = 16,
  parameter int fifoDepth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [addrWidth-1:0] base_addr_i,
  input  logic [lenWidth-1:0]  num_words_i,
  input  logic [addrWidth-1:0] stride_i,
`ifdef RAM_STREAM_READER_ABORT_EN
  input  logic                 abort_i,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rd_en_o,
  output logic [addrWidth-1:0] rd_addr_o,
  input  logic [dataWidth-1:0] rd_data_i,
  ram_stream_if.master         m
);

  localparam int OCC_W = $clog2(fifoDepth) + 1;
  localparam int CRD_W = $clog2(fifoDepth) + 2;

  state_e               state_q, state_d;
  logic [lenWidth-1:0]  cnt_q, cnt_d, num_q, num_d;
  logic [addrWidth-1:0] stride_q, stride_d, next_addr_q, next_addr_d;
  logic [addrWidth-1:0] rd_addr_q, rd_addr_d;
  logic                 rd_en_q, rd_en_d, rd_last_q, rd_last_d;
  logic                 resp_vld_q, resp_vld_d, resp_last_q, resp_last_d;

  logic                 abort_act, pop, push, fifo_empty, credit_ok;
  logic [OCC_W-1:0]     occ;
  logic [CRD_W-1:0]     credit_sum;
  fifo_entry_t          push_entry, head;

`ifdef RAM_STREAM_READER_ABORT_EN
  assign abort_act = abort_i && ((state_q == RUN) || (state_q == DRAIN));
`else
  assign abort_act = 1'b0;
`endif

  assign pop  = ~fifo_empty & m.m_ready_i;
  assign push = resp_vld_q & ~abort_act;

  always_comb begin
    push_entry      = '0;
    push_entry.last = resp_last_q;
    push_entry.data = WORD_W'(rd_data_i);
  end

  // Every issued read already owns a slot: occupancy plus both pipeline stages.
  assign credit_sum = CRD_W'(occ) + CRD_W'(rd_en_q) + CRD_W'(resp_vld_q);
  assign credit_ok  = credit_sum < (CRD_W'(fifoDepth) + CRD_W'(pop));

  ram_stream_fifo #(
    .width ($bits(fifo_entry_t)),
    .depth (fifoDepth)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (abort_act),
    .count_o     (occ),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    stride_d    = stride_q;
    next_addr_d = next_addr_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_last_d   = 1'b0;
    resp_vld_d  = rd_en_q;
    resp_last_d = rd_last_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          num_d    = num_words_i;
          stride_d = stride_i;
          cnt_d    = '0;
          if (num_words_i == '0) begin
            state_d = DONE;
          end else begin
            // First read issues straight from IDLE so rd_en_o rises the cycle after start.
            state_d     = RUN;
            rd_en_d     = 1'b1;
            rd_addr_d   = base_addr_i;
            next_addr_d = base_addr_i + stride_i;
            cnt_d       = lenWidth'(1);
            rd_last_d   = (num_words_i == lenWidth'(1));
          end
        end
      end
      RUN: begin
        if ((cnt_q != num_q) && credit_ok) begin
          rd_en_d     = 1'b1;
          rd_addr_d   = next_addr_q;
          next_addr_d = next_addr_q + stride_q;
          cnt_d       = cnt_q + lenWidth'(1);
          rd_last_d   = (cnt_d == num_q);
        end
        if (cnt_d == num_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head.last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (abort_act) begin
      state_d    = IDLE;
      cnt_d      = '0;
      rd_en_d    = 1'b0;
      rd_last_d  = 1'b0;
      resp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_last_q   <= 1'b0;
      resp_vld_q  <= 1'b0;
      resp_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_last_q   <= rd_last_d;
      resp_vld_q  <= resp_vld_d;
      resp_last_q <= resp_last_d;
    end
  end

  always_ff @(posedge clk) begin
    num_q       <= num_d;
    stride_q    <= stride_d;
    next_addr_q <= next_addr_d;
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign m.m_valid_o = ~fifo_empty;
  assign m.m_data_o  = head.data[dataWidth-1:0];
  assign m.m_last_o  = head.last;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: stimulus queues expected reads/words, a monitor checks them.
module tb_ram_stream_reader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  base = '0;
  logic [15:0]  num = '0;
  logic [31:0]  stride = '0;
  logic         busy, done, rd_en;
  logic [31:0]  rd_addr;
  logic [255:0] rd_data = '0;
`ifdef RAM_STREAM_READER_ABORT_EN
  logic         abort = 1'b0;
`endif

  ram_stream_if #(.dataWidth(256)) sif ();

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_hs_cyc = -1;
  logic [31:0]  exp_addr [$];
  logic [256:0] exp_data [$];

  ram_stream_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .base_addr_i (base),
    .num_words_i (num),
    .stride_i    (stride),
`ifdef RAM_STREAM_READER_ABORT_EN
    .abort_i     (abort),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .rd_en_o     (rd_en),
    .rd_addr_o   (rd_addr),
    .rd_data_i   (rd_data),
    .m           (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] ram_word(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_0000}};
  endfunction

  // RAM port 2 model: one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= ram_word(rd_addr);

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] a, input logic last);
    exp_addr.push_back(a);
    exp_data.push_back({last, ram_word(a)});
  endtask

  task automatic start_cmd(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s,
                           output int sc);
    tick();
    start = 1'b1; base = b; num = n; stride = s;
    @(negedge clk);
    sc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit toggle, output int dc);
    bit found = 1'b0;
    dc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        dc = cyc;
        break;
      end
      if (toggle) begin
        @(posedge clk);
        #1;
        sif.m_ready_i = ~sif.m_ready_i;
      end
    end
    if (!found) begin
      n_checks++;
      $display("FAIL done_timeout: done_o not seen in 200 cycles, required a pulse");
    end else begin
      check("done_after_last", dc, last_hs_cyc + 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_fall", busy, 0);
    end
    sif.m_ready_i = 1'b1;
  endtask

  task automatic check_drained(input string name);
    check({name, "_addr_left"}, exp_addr.size(), 0);
    check({name, "_data_left"}, exp_data.size(), 0);
  endtask

  // Monitor: every read request and every accepted word is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        if (exp_addr.size() == 0) begin
          n_checks++;
          $display("FAIL rd_unexpected: got read of %h, required no read", rd_addr);
        end else begin
          check("rd_addr", rd_addr, exp_addr.pop_front());
        end
      end
      if (sif.m_valid_o && sif.m_ready_i) begin
        if (exp_data.size() == 0) begin
          n_checks++;
          $display("FAIL word_unexpected: got word %h, required none", sif.m_data_o);
        end else begin
          logic [256:0] e;
          e = exp_data.pop_front();
          check("m_data", sif.m_data_o, e[255:0]);
          check("m_last", sif.m_last_o, e[256]);
          if (sif.m_last_o) last_hs_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sc, dc, nrd;
    sif.m_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_m_valid", sif.m_valid_o, 0);
    check("rst_m_data", sif.m_data_o, 0);
    check("rst_m_last", sif.m_last_o, 0);
    tick();
    rst = 1'b0;

    // Basic 4-word stream, full throughput.
    expect_word(32'h40, 1'b0);
    expect_word(32'h60, 1'b0);
    expect_word(32'h80, 1'b0);
    expect_word(32'hA0, 1'b1);
    start_cmd(32'h40, 16'd4, 32'd32, sc);
    @(negedge clk);
    check("t1_rd_en_T1", rd_en, 1);
    @(negedge clk);
    check("t1_valid_T2", sif.m_valid_o, 0);
    @(negedge clk);
    check("t1_valid_T3", sif.m_valid_o, 1);
    wait_done(1'b0, dc);
    check("t1_done_T7", dc - sc, 7);
    check_drained("t1");

    // Zero-length command.
    start_cmd(32'h1234, 16'd0, 32'd8, sc);
    @(negedge clk);
    check("t2_done_T1", done, 1);
    check("t2_busy_T1", busy, 1);
    @(negedge clk);
    check("t2_done_T2", done, 0);
    check("t2_busy_T2", busy, 0);
    check("t2_valid", sif.m_valid_o, 0);

    // Backpressure: 8 words, consumer stalled for 10 cycles.
    for (int k = 0; k < 8; k++) expect_word(32'h1000 + 32'h40 * k, k == 7);
    tick();
    sif.m_ready_i = 1'b0;
    start_cmd(32'h1000, 16'd8, 32'h40, sc);
    nrd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_en) nrd++;
    end
    check("t3_reads_stalled", nrd, 4);
    check("t3_valid_stalled", sif.m_valid_o, 1);
    tick();
    sif.m_ready_i = 1'b1;
    wait_done(1'b0, dc);
    check_drained("t3");

    // Address wrap.
    expect_word(32'hFFFF_FFE0, 1'b0);
    expect_word(32'h0000_0000, 1'b1);
    start_cmd(32'hFFFF_FFE0, 16'd2, 32'd32, sc);
    wait_done(1'b0, dc);
    check_drained("t4");

    // start_i during RUN is ignored; consumer toggles ready.
    for (int k = 0; k < 6; k++) expect_word(32'h200 + 32'h10 * k, k == 5);
    start_cmd(32'h200, 16'd6, 32'h10, sc);
    tick();
    start = 1'b1; base = 32'h9000; num = 16'd3; stride = 32'd4;
    tick();
    start = 1'b0;
    wait_done(1'b1, dc);
    check_drained("t5");

    // Reset mid-RUN, then a clean command.
    for (int k = 0; k < 8; k++) expect_word(32'h3000 + 32'h8 * k, k == 7);
    start_cmd(32'h3000, 16'd8, 32'h8, sc);
    tick();
    rst = 1'b1;
    exp_addr.delete();
    exp_data.delete();
    tick();
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_rd_en", rd_en, 0);
    check("t6_rd_addr", rd_addr, 0);
    check("t6_valid", sif.m_valid_o, 0);
    check("t6_m_data", sif.m_data_o, 0);
    tick();
    rst = 1'b0;
    expect_word(32'h100, 1'b0);
    expect_word(32'h200, 1'b0);
    expect_word(32'h300, 1'b1);
    start_cmd(32'h100, 16'd3, 32'h100, sc);
    wait_done(1'b0, dc);
    check_drained("t6");

`ifdef RAM_STREAM_READER_ABORT_EN
    // Abort after three reads with the consumer stalled.
    for (int k = 0; k < 8; k++) expect_word(32'h5000 + 32'h20 * k, k == 7);
    tick();
    sif.m_ready_i = 1'b0;
    start_cmd(32'h5000, 16'd8, 32'h20, sc);
    nrd = 0;
    for (int i = 0; i < 20 && nrd < 3; i++) begin
      @(negedge clk);
      if (rd_en) nrd++;
    end
    check("t7_reads_before_abort", nrd, 3);
    tick();
    abort = 1'b1;
    @(negedge clk);
    tick();
    abort = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    @(negedge clk);
    check("t7_valid_after", sif.m_valid_o, 0);
    check("t7_rd_en_after", rd_en, 0);
    check("t7_busy_after", busy, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t7_no_done", done, 0);
      check("t7_no_valid", sif.m_valid_o, 0);
    end
    tick();
    sif.m_ready_i = 1'b1;
    expect_word(32'h40, 1'b0);
    expect_word(32'h60, 1'b1);
    start_cmd(32'h40, 16'd2, 32'd32, sc);
    wait_done(1'b0, dc);
    check_drained("t7");
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
